// File: rtl/jedec_p.sv
// Shared definitions for the device-side eMMC CMD-line engine: frame lengths,
// response kinds, FSM states and the serial CRC7 step.
package jedec_p;

  localparam int CMD_LEN = 48;
  localparam int R1_LEN  = 48;
  localparam int R2_LEN  = 136;

  localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  typedef enum logic [1:0] {
    NONE = 2'd0,
    R1   = 2'd1,
    R2   = 2'd2,
    R3   = 2'd3
  } rsp_kind_t;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    CHECK,
    WAIT_RSP,
    SEND
  } emmc_dev_state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/emmc_crc7.sv
// Serial CRC7 accumulator, MSB-first. Clear has priority over enable; the
// register holds its value while neither is asserted.
module emmc_crc7
  import jedec_p::*;
(
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values and simulation matches the synthesised netlist.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      crc_o <= 7'h00;
    end else if (clr_i) begin
      crc_o <= 7'h00;
    end else if (en_i) begin
      crc_o <= crc7_step(crc_o, bit_i);
    end
  end

endmodule

// File: rtl/emmc_dev_cmd.sv
// Card-side eMMC CMD-line engine: receives 48-bit host commands, validates
// them, and returns R1/R2/R3 responses inside the NCR window.
module emmc_dev_cmd
  import jedec_p::*;
#(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         emmc_cmd_i,
  output logic         emmc_cmd_o,
  output logic         emmc_cmd_oe_o,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_idx_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_err_o,
  output logic         rsp_ready_o,
  input  logic         rsp_valid_i,
  input  logic [1:0]   rsp_kind_i,
  input  logic [5:0]   rsp_idx_i,
  input  logic [119:0] rsp_data_i,
  output logic         rsp_timeout_o,
  output logic         busy_o
);

  localparam int         NCR_W       = $clog2(NCR_MAX + 1);
  localparam logic [7:0] BIT_CNT_MAX = 8'(R2_LEN - 1);
  localparam logic [7:0] RX_LAST     = 8'(CMD_LEN - 1);
  localparam logic [7:0] RX_CRC_END  = 8'd40;

  emmc_dev_state_t     state_q, state_d;
  logic [7:0]          bit_cnt_q;
  logic [CMD_LEN-2:0]  rx_sr_q;
  logic [NCR_W-1:0]    ncr_cnt_q;
  logic                hs_done_q;
  logic [R2_LEN-1:0]   tx_sr_q;
  rsp_kind_t           tx_kind_q;

  logic [6:0]          crc;
  logic                crc_clr, crc_en, crc_bit;

  logic [CMD_LEN-1:0]  rx_frame;
  logic                rx_last, rx_ok;
  logic                hs, ncr_min_met;
  rsp_kind_t           rsp_kind;
  logic                tx_has_crc, in_crc_field, tx_bit;
  logic [7:0]          crc_first, crc_start, tx_last;
  logic [2:0]          crc_off;
  logic [7:0]          bit_cnt_inc;

  function automatic logic [R2_LEN-1:0] build_frame(input rsp_kind_t   kind,
                                                    input logic [5:0]   idx,
                                                    input logic [119:0] data);
    logic [R2_LEN-1:0] f;
    case (kind)
      R1:      f = {2'b00, idx,   data[31:0], 7'h00, 1'b1, 88'd0};
      R2:      f = {2'b00, 6'h3F, data,       7'h00, 1'b1};
      R3:      f = {2'b00, 6'h3F, data[31:0], 7'h7F, 1'b1, 88'd0};
      default: f = '0;
    endcase
    return f;
  endfunction

  // Receive-side decode: rx_frame[47-k] is bit k of the command on the wire.
  assign rx_frame = {rx_sr_q, emmc_cmd_i};
  assign rx_last  = (state_q == RECV) && (bit_cnt_q == RX_LAST);
  assign rx_ok    = !rx_frame[47] && rx_frame[46] && rx_frame[0] &&
                    (rx_frame[7:1] == crc);

  assign rsp_kind    = rsp_kind_t'(rsp_kind_i);
  assign hs          = rsp_valid_i && rsp_ready_o;
  // The CHECK cycle and the current WAIT_RSP cycle both count as idle clocks.
  assign ncr_min_met = (int'(ncr_cnt_q) + 2) >= NCR_MIN;

  assign tx_has_crc   = (tx_kind_q != R3);
  assign crc_first    = (tx_kind_q == R2) ? 8'd8 : 8'd0;
  assign crc_start    = (tx_kind_q == R2) ? 8'd128 : 8'd40;
  assign tx_last      = (tx_kind_q == R2) ? 8'(R2_LEN - 1) : 8'(R1_LEN - 1);
  assign in_crc_field = tx_has_crc && (bit_cnt_q >= crc_start) &&
                        (bit_cnt_q < crc_start + 8'd7);
  assign crc_off      = 3'(bit_cnt_q - crc_start);
  assign tx_bit       = in_crc_field ? crc[3'd6 - crc_off] : tx_sr_q[R2_LEN-1];

  assign bit_cnt_inc  = (bit_cnt_q == BIT_CNT_MAX) ? bit_cnt_q : bit_cnt_q + 8'd1;

  assign busy_o        = (state_q != IDLE);
  assign emmc_cmd_oe_o = (state_q == SEND);
  assign emmc_cmd_o    = (state_q == SEND) ? tx_bit : 1'b1;
  assign rsp_ready_o   = (state_q == WAIT_RSP) && !hs_done_q &&
                         (ncr_cnt_q < NCR_W'(NCR_MAX));
  assign rsp_timeout_o = (state_q == WAIT_RSP) && !hs_done_q &&
                         (ncr_cnt_q == NCR_W'(NCR_MAX));

  // The single CRC engine serves reception and transmission in turn.
  always_comb begin
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_bit = emmc_cmd_i;
    case (state_q)
      IDLE:     crc_clr = 1'b1;
      RECV:     crc_en  = (bit_cnt_q < RX_CRC_END);
      WAIT_RSP: crc_clr = 1'b1;
      SEND: begin
        crc_bit = tx_bit;
        crc_en  = tx_has_crc && (bit_cnt_q >= crc_first) && (bit_cnt_q < crc_start);
      end
      default: ;
    endcase
  end

  emmc_crc7 u_crc7 (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .clr_i   (crc_clr),
    .en_i    (crc_en),
    .bit_i   (crc_bit),
    .crc_o   (crc)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!emmc_cmd_i) state_d = RECV;
      RECV:     if (rx_last) state_d = CHECK;
      CHECK:    state_d = cmd_valid_o ? WAIT_RSP : IDLE;
      WAIT_RSP: begin
        if (hs && (rsp_kind == NONE))           state_d = IDLE;
        else if ((hs || hs_done_q) && ncr_min_met) state_d = SEND;
        else if (rsp_timeout_o)                 state_d = IDLE;
      end
      SEND:     if (bit_cnt_q == tx_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: the shift registers are reset along with the control state so the
  // CMD outputs and held fields are defined from the first clock after reset.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      bit_cnt_q   <= 8'd0;
      rx_sr_q     <= '0;
      ncr_cnt_q   <= '0;
      hs_done_q   <= 1'b0;
      tx_sr_q     <= '0;
      tx_kind_q   <= NONE;
      cmd_valid_o <= 1'b0;
      cmd_err_o   <= 1'b0;
      cmd_idx_o   <= 6'd0;
      cmd_arg_o   <= 32'd0;
    end else begin
      cmd_valid_o <= rx_last && rx_ok;
      cmd_err_o   <= rx_last && !rx_ok;
      if (rx_last && rx_ok) begin
        cmd_idx_o <= rx_frame[45:40];
        cmd_arg_o <= rx_frame[39:8];
      end

      case (state_q)
        IDLE: begin
          // The start bit (0) is already represented by the cleared LSB.
          bit_cnt_q <= 8'd1;
          rx_sr_q   <= '0;
        end
        RECV: begin
          bit_cnt_q <= bit_cnt_inc;
          rx_sr_q   <= {rx_sr_q[CMD_LEN-3:0], emmc_cmd_i};
        end
        CHECK: begin
          bit_cnt_q <= 8'd0;
          ncr_cnt_q <= '0;
          hs_done_q <= 1'b0;
        end
        WAIT_RSP: begin
          bit_cnt_q <= 8'd0;
          if (ncr_cnt_q != NCR_W'(NCR_MAX)) ncr_cnt_q <= ncr_cnt_q + 1'b1;
          if (hs) begin
            hs_done_q <= 1'b1;
            tx_kind_q <= rsp_kind;
            tx_sr_q   <= build_frame(rsp_kind, rsp_idx_i, rsp_data_i);
          end
        end
        SEND: begin
          bit_cnt_q <= bit_cnt_inc;
          tx_sr_q   <= {tx_sr_q[R2_LEN-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_emmc_dev_cmd.sv
// Directed bench for emmc_dev_cmd: host-side command frames driven bit by bit,
// responses captured from the CMD line and compared with hand-built frames.
module tb_emmc_dev_cmd;

  logic         clk_i = 1'b0;
  logic         arst_ni = 1'b0;
  logic         emmc_cmd_i = 1'b1;
  logic         emmc_cmd_o;
  logic         emmc_cmd_oe_o;
  logic         cmd_valid_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;
  logic         cmd_err_o;
  logic         rsp_ready_o;
  logic         rsp_valid_i = 1'b0;
  logic [1:0]   rsp_kind_i = 2'd0;
  logic [5:0]   rsp_idx_i = 6'd0;
  logic [119:0] rsp_data_i = '0;
  logic         rsp_timeout_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  localparam logic [119:0] CID = 120'h1501004D4D43_3132333435363738_0A;

  always #5 clk_i = ~clk_i;

  emmc_dev_cmd #(.NCR_MIN(2), .NCR_MAX(64)) dut (
    .clk_i         (clk_i),
    .arst_ni       (arst_ni),
    .emmc_cmd_i    (emmc_cmd_i),
    .emmc_cmd_o    (emmc_cmd_o),
    .emmc_cmd_oe_o (emmc_cmd_oe_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_idx_o     (cmd_idx_o),
    .cmd_arg_o     (cmd_arg_o),
    .cmd_err_o     (cmd_err_o),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_kind_i    (rsp_kind_i),
    .rsp_idx_i     (rsp_idx_i),
    .rsp_data_i    (rsp_data_i),
    .rsp_timeout_o (rsp_timeout_o),
    .busy_o        (busy_o)
  );

  // Reference CRC7 over the low n bits of 'bits', MSB first.
  function automatic logic [6:0] crc7_model(input logic [119:0] bits, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, crc7_model(120'(body), 40), 1'b1};
  endfunction

  // Drives a 48-bit frame; returns at the negedge of the CHECK cycle.
  task automatic send_cmd(input logic [47:0] frame);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk_i);
      emmc_cmd_i = frame[47-k];
    end
    @(negedge clk_i);
    emmc_cmd_i = 1'b1;
  endtask

  // Called at the CHECK negedge: offers a response, returns at the first
  // negedge where the start bit should be on the line, counting idle clocks.
  task automatic offer_rsp(input logic [1:0] kind, input logic [5:0] idx,
                           input logic [119:0] data, output int idle_clks);
    idle_clks = 0;
    if (!emmc_cmd_oe_o) idle_clks++;
    rsp_valid_i = 1'b1;
    rsp_kind_i  = kind;
    rsp_idx_i   = idx;
    rsp_data_i  = data;
    @(negedge clk_i);
    if (!emmc_cmd_oe_o) idle_clks++;
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
  endtask

  task automatic capture_rsp(input int n, output logic [135:0] bits, output int oe_low);
    bits   = '0;
    oe_low = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk_i);
      if (emmc_cmd_oe_o !== 1'b1) oe_low++;
      bits = {bits[134:0], emmc_cmd_o};
    end
  endtask

  task automatic test_reset;
    arst_ni    = 1'b0;
    emmc_cmd_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({emmc_cmd_o, emmc_cmd_oe_o, cmd_valid_o, cmd_err_o, rsp_timeout_o, rsp_ready_o, busy_o} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 1000000",
               {emmc_cmd_o, emmc_cmd_oe_o, cmd_valid_o, cmd_err_o, rsp_timeout_o, rsp_ready_o, busy_o});
    end
    checks++;
    if (cmd_idx_o !== 6'd0 || cmd_arg_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_fields: idx %0d arg %h expected 0 00000000", cmd_idx_o, cmd_arg_o);
    end
    @(negedge clk_i);
    arst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_cmd0_none;
    int oe_hits;
    oe_hits = 0;
    send_cmd(48'h40_0000_0000_95);
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_err_o !== 1'b0) begin
      errors++;
      $display("FAIL cmd0_pulses: valid %b err %b expected 1 0", cmd_valid_o, cmd_err_o);
    end
    checks++;
    if (cmd_idx_o !== 6'd0 || cmd_arg_o !== 32'd0) begin
      errors++;
      $display("FAIL cmd0_fields: idx %0d arg %h expected 0 00000000", cmd_idx_o, cmd_arg_o);
    end
    rsp_valid_i = 1'b1;
    rsp_kind_i  = 2'd0;
    @(negedge clk_i);
    if (emmc_cmd_oe_o) oe_hits++;
    checks++;
    if (rsp_ready_o !== 1'b1 || busy_o !== 1'b1 || cmd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL cmd0_wait: ready %b busy %b valid %b expected 1 1 0", rsp_ready_o, busy_o, cmd_valid_o);
    end
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || rsp_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL cmd0_after_hs: busy %b ready %b expected 0 0", busy_o, rsp_ready_o);
    end
    for (int k = 0; k < 5; k++) begin
      if (emmc_cmd_oe_o) oe_hits++;
      @(negedge clk_i);
    end
    checks++;
    if (oe_hits != 0) begin
      errors++;
      $display("FAIL cmd0_no_drive: oe seen %0d cycles expected 0", oe_hits);
    end
  endtask

  task automatic test_r1_ncr_min;
    int           idle, oe_low;
    logic [135:0] got;
    logic [39:0]  body;
    logic [47:0]  exp;
    body = {2'b00, 6'd17, 32'h0000_0900};
    exp  = {body, crc7_model(120'(body), 40), 1'b1};
    send_cmd(48'h51_0000_0000_55);
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_idx_o !== 6'd17 || cmd_arg_o !== 32'd0) begin
      errors++;
      $display("FAIL cmd17_rx: valid %b idx %0d arg %h expected 1 17 00000000", cmd_valid_o, cmd_idx_o, cmd_arg_o);
    end
    offer_rsp(2'd1, 6'd17, 120'h900, idle);
    checks++;
    if (idle != 2 || emmc_cmd_oe_o !== 1'b1) begin
      errors++;
      $display("FAIL r1_ncr: idle clocks %0d oe %b expected 2 1", idle, emmc_cmd_oe_o);
    end
    checks++;
    if (rsp_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL r1_ready_drop: got %b expected 0", rsp_ready_o);
    end
    capture_rsp(48, got, oe_low);
    checks++;
    if (got[47:0] !== exp || oe_low != 0) begin
      errors++;
      $display("FAIL r1_frame: got %h (oe low %0d) expected %h", got[47:0], oe_low, exp);
    end
    @(negedge clk_i);
    checks++;
    if (emmc_cmd_oe_o !== 1'b0 || emmc_cmd_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL r1_release: oe %b cmd %b busy %b expected 0 1 0", emmc_cmd_oe_o, emmc_cmd_o, busy_o);
    end
  endtask

  task automatic test_r2_cid;
    int           idle, oe_low;
    logic [135:0] got, exp;
    exp = {2'b00, 6'h3F, CID, crc7_model(CID, 120), 1'b1};
    send_cmd(mk_cmd(6'd2, 32'd0));
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_idx_o !== 6'd2) begin
      errors++;
      $display("FAIL cmd2_rx: valid %b idx %0d expected 1 2", cmd_valid_o, cmd_idx_o);
    end
    offer_rsp(2'd2, 6'd0, CID, idle);
    capture_rsp(136, got, oe_low);
    checks++;
    if (got[133:128] !== 6'h3F || got[0] !== 1'b1) begin
      errors++;
      $display("FAIL r2_fixed_bits: reserved %h end %b expected 3f 1", got[133:128], got[0]);
    end
    checks++;
    if (got[7:1] !== crc7_model(CID, 120)) begin
      errors++;
      $display("FAIL r2_crc: got %h expected %h", got[7:1], crc7_model(CID, 120));
    end
    checks++;
    if (got !== exp || oe_low != 0 || idle != 2) begin
      errors++;
      $display("FAIL r2_frame: got %h (oe low %0d, idle %0d) expected %h", got, oe_low, idle, exp);
    end
    @(negedge clk_i);
    checks++;
    if (emmc_cmd_oe_o !== 1'b0) begin
      errors++;
      $display("FAIL r2_release: oe %b expected 0", emmc_cmd_oe_o);
    end
  endtask

  task automatic test_timeout;
    int n, ready_low;
    send_cmd(mk_cmd(6'd1, 32'h40FF_8080));
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_idx_o !== 6'd1 || cmd_arg_o !== 32'h40FF_8080) begin
      errors++;
      $display("FAIL cmd1_rx: valid %b idx %0d arg %h expected 1 1 40ff8080", cmd_valid_o, cmd_idx_o, cmd_arg_o);
    end
    n = 0;
    ready_low = 0;
    while (n < 200 && rsp_timeout_o !== 1'b1) begin
      @(negedge clk_i);
      n++;
      if (rsp_timeout_o !== 1'b1 && rsp_ready_o !== 1'b1) ready_low++;
    end
    checks++;
    if (n != 65 || ready_low != 0) begin
      errors++;
      $display("FAIL ncr_timeout: pulse after %0d cycles (ready low %0d) expected 65 0", n, ready_low);
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || rsp_timeout_o !== 1'b0 || emmc_cmd_oe_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: busy %b timeout %b oe %b expected 0 0 0", busy_o, rsp_timeout_o, emmc_cmd_oe_o);
    end
  endtask

  task automatic test_crc_error;
    int oe_hits;
    oe_hits = 0;
    send_cmd(48'h51_0000_0000_55 ^ 48'h00_0000_0000_04);
    checks++;
    if (cmd_err_o !== 1'b1 || cmd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL crc_err_pulse: err %b valid %b expected 1 0", cmd_err_o, cmd_valid_o);
    end
    checks++;
    if (cmd_idx_o !== 6'd1 || cmd_arg_o !== 32'h40FF_8080) begin
      errors++;
      $display("FAIL crc_err_hold: idx %0d arg %h expected 1 40ff8080", cmd_idx_o, cmd_arg_o);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (emmc_cmd_oe_o) oe_hits++;
    end
    checks++;
    if (busy_o !== 1'b0 || cmd_err_o !== 1'b0 || oe_hits != 0) begin
      errors++;
      $display("FAIL crc_err_idle: busy %b err %b oe cycles %0d expected 0 0 0", busy_o, cmd_err_o, oe_hits);
    end
  endtask

  task automatic test_r3_after_error;
    int           idle, oe_low;
    logic [135:0] got;
    logic [47:0]  exp;
    exp = {2'b00, 6'h3F, 32'hCAFE_F00D, 7'h7F, 1'b1};
    send_cmd(mk_cmd(6'd17, 32'h0000_1234));
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_idx_o !== 6'd17 || cmd_arg_o !== 32'h0000_1234) begin
      errors++;
      $display("FAIL cmd17b_rx: valid %b idx %0d arg %h expected 1 17 00001234", cmd_valid_o, cmd_idx_o, cmd_arg_o);
    end
    offer_rsp(2'd3, 6'd0, 120'hCAFE_F00D, idle);
    capture_rsp(48, got, oe_low);
    checks++;
    if (got[47:0] !== exp || oe_low != 0 || idle != 2) begin
      errors++;
      $display("FAIL r3_frame: got %h (oe low %0d, idle %0d) expected %h", got[47:0], oe_low, idle, exp);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_send;
    int           idle, oe_low;
    logic [135:0] got;
    send_cmd(mk_cmd(6'd2, 32'd0));
    offer_rsp(2'd2, 6'd0, CID, idle);
    capture_rsp(60, got, oe_low);
    @(negedge clk_i);
    checks++;
    if (emmc_cmd_oe_o !== 1'b1 || oe_low != 0) begin
      errors++;
      $display("FAIL mid_send_active: oe %b (oe low %0d) expected 1 0", emmc_cmd_oe_o, oe_low);
    end
    #2 arst_ni = 1'b0;
    #1;
    checks++;
    if (emmc_cmd_oe_o !== 1'b0 || emmc_cmd_o !== 1'b1) begin
      errors++;
      $display("FAIL async_release: oe %b cmd %b expected 0 1", emmc_cmd_oe_o, emmc_cmd_o);
    end
    @(negedge clk_i);
    arst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (cmd_idx_o !== 6'd0 || cmd_arg_o !== 32'd0 || busy_o !== 1'b0 || rsp_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: idx %0d arg %h busy %b ready %b expected 0 0 0 0", cmd_idx_o, cmd_arg_o, busy_o, rsp_ready_o);
    end
    send_cmd(48'h40_0000_0000_95);
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_err_o !== 1'b0 || cmd_idx_o !== 6'd0 || cmd_arg_o !== 32'd0) begin
      errors++;
      $display("FAIL cmd0_after_reset: valid %b err %b idx %0d arg %h expected 1 0 0 00000000",
               cmd_valid_o, cmd_err_o, cmd_idx_o, cmd_arg_o);
    end
    rsp_valid_i = 1'b1;
    rsp_kind_i  = 2'd0;
    repeat (2) @(negedge clk_i);
    rsp_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cmd0_none();
    test_r1_ncr_min();
    test_r2_cid();
    test_timeout();
    test_crc_error();
    test_r3_after_error();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/emmc_dev_cmd.md
Name: emmc_dev_cmd

Overview:
- Device-side (card-end) eMMC CMD-line engine, the counterpart of the host emmc_sm command handler.
- Deserialises 48-bit host commands, checks the frame and CRC7, and presents index and argument to a device model.
- Then serialises the R1/R3 (48-bit) or R2 (136-bit) response inside the JEDEC NCR window.
- Used as the card side of simulation benches and as a loopback target on FPGA.

Parameters:
- NCR_MIN, 2, minimum idle clocks between command end bit and response start bit.
- NCR_MAX, 64, maximum idle clocks; if no response is offered by then, the response is abandoned.

Ports:
- clk_i  in  1  eMMC bus clock (pad clock); all sampling and driving on rising edge.
- arst_ni  in  1  asynchronous active-low reset.
- emmc_cmd_i  in  1  CMD line sampled value.
- emmc_cmd_o  out  1  CMD drive value.
- emmc_cmd_oe_o  out  1  CMD output enable.
- cmd_valid_o  out  1  one-cycle pulse: clean command received.
- cmd_idx_o  out  6  command index, held until the next command.
- cmd_arg_o  out  32  command argument, held until the next command.
- cmd_err_o  out  1  one-cycle pulse: CRC or framing error.
- rsp_ready_o  out  1  high while a response is accepted.
- rsp_valid_i  in  1  response offer; handshake completes when valid && ready.
- rsp_kind_i  in  2  jedec_p::rsp_kind_t: NONE=0, R1=1, R2=2, R3=3.
- rsp_idx_i  in  6  R1 index field.
- rsp_data_i  in  120  R1/R3 use [31:0]; R2 uses all bits as CID/CSD[127:8].
- rsp_timeout_o  out  1  one-cycle pulse: NCR_MAX expired.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: cmd_o=1, oe=0, all pulses 0, idx/arg 0, rsp_ready_o 0, busy_o 0, FSM in IDLE. Reset mid-send releases the line immediately (async).
- IDLE: while oe=0, a sampled 0 on emmc_cmd_i is the start bit. Go to RECV with the bit counter at 1 and CRC seeded with 0.
- RECV: shift 47 further bits MSB-first.
  - Bit 1 (transmission) must be 1.
  - CRC7 runs over bits 0..39; bits 40..46 are compared with it; bit 47 (end) must be 1.
- CHECK (1 cycle after the end bit): exactly one of cmd_valid_o or cmd_err_o pulses. idx/arg update only on a clean command.
  - Error: return to IDLE, no response.
  - Clean: go to WAIT_RSP with the NCR counter at 0.
- WAIT_RSP: rsp_ready_o=1; the counter increments each cycle.
  - Handshake with kind NONE: go to IDLE.
  - Otherwise latch the frame; the start bit is driven on the first cycle where counter ≥ NCR_MIN and the handshake has completed.
  - Counter reaching NCR_MAX without a handshake: rsp_timeout_o pulses, go to IDLE.
  - rsp_ready_o drops the cycle after the handshake.
- SEND: oe=1, MSB-first, one bit per clock.
  - R1: 0,0,idx[5:0],arg[31:0],crc7 over first 40 bits,1.
  - R3: 0,0,111111,arg,1111111,1.
  - R2: 0,0,111111,data[119:0],crc7 over data only,1.
- After the end bit, oe deasserts the next cycle and the FSM returns to IDLE. The CMD input is ignored while oe=1.
- Bit counter is 8 bits and saturates at 135; no wrap.

Decomposition:
- jedec_p: CMD_LEN=48, R1_LEN=48, R2_LEN=136, rsp_kind_t, emmc_dev_state_t (IDLE, RECV, CHECK, WAIT_RSP, SEND).
- Sub-module emmc_crc7: serial CRC7 (poly x^7+x^3+1) with clear/enable/bit inputs, shared by the RX and TX paths (used sequentially).

Test Plan:
- CMD0 (frame 40 00000000 95), respond NONE -> cmd_valid_o pulse, idx=0, arg=0; oe never asserts; busy_o low 1 cycle after handshake.
- CMD17 arg 0 (frame 51 00000000 55), R1 idx 17 data 0x00000900 at NCR_MIN -> start bit exactly 2 idle clocks after end bit; 48 bits match the model CRC; oe low afterwards.
- CMD2 then R2 with data 0x1501004D4D43…(120 bits) -> 136-bit frame, bits 2..7 = 111111, CRC7 over data matches the model, end bit 1.
- CMD17 with one CRC bit flipped -> cmd_err_o pulse, no cmd_valid_o, idx/arg keep the previous values, no drive.
- Clean CMD1 but rsp_valid_i never asserted -> rsp_timeout_o pulse at counter 64, FSM in IDLE. A following command is received normally.
- arst_ni low at R2 bit 60 -> oe=0 and cmd_o=1 asynchronously. After release, a new CMD0 is decoded correctly.
